// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access initiator.
// Readback word carries even parity in its MSB.
package mem_access_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic even_parity_ok(input logic [MEM_DATA_W:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/mem_access_master.sv
// Single-request memory initiator: issues one write or read strobe, checks readback
// parity, reissues failed reads up to MAX_RETRY times and returns one response.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic [2:0]        rsp_retries,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W:0]   mem_data_out,
  output logic              busy
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);
  localparam logic [2:0] MAX_R  = 3'(MAX_RETRY);

  state_e     state, state_nxt;
  logic [2:0] wait_cnt;
  logic       accept, sample, retry, par_ok;

  assign par_ok = even_parity_ok(mem_data_out);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    retry     = 1'b0;
    case (state)
      IDLE: if (req_ready && req_valid) begin
        accept    = 1'b1;
        state_nxt = req_we ? WR : RD;
      end
      WR:   state_nxt = RESP;
      RD:   state_nxt = WAIT;
      WAIT: if (wait_cnt == 3'd0) begin
        sample = 1'b1;
        if (!par_ok && (rsp_retries < MAX_R)) begin
          retry     = 1'b1;
          state_nxt = RD;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a flop fed from the next state, so strobes line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      rsp_retries <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      mem_write <= (state_nxt == WR);
      mem_read  <= (state_nxt == RD);
      rsp_valid <= (state_nxt == RESP);

      if (accept) begin
        mem_address <= req_addr;
        mem_data_in <= req_wdata;
        rsp_rdata   <= '0;
        rsp_perr    <= 1'b0;
        rsp_retries <= '0;
      end

      if (state == RD)
        wait_cnt <= LAT_M1;
      else if (state == WAIT && wait_cnt != 3'd0)
        wait_cnt <= wait_cnt - 3'd1;

      if (sample) begin
        rsp_rdata <= mem_data_out[DATA_W-1:0];
        rsp_perr  <= !par_ok && !retry;
        if (retry) rsp_retries <= rsp_retries + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized self-checking bench for mem_access_master with a transaction-level model.
module tb_mem_access_master;
  localparam int RD_LAT = 1;
  localparam int MAXR   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_perr, mem_write, mem_read, busy;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata, mem_data_in;
  logic [2:0]  rsp_retries;
  logic [15:0] mem_address;
  logic [8:0]  mem_data_out = '0;

  int checks = 0, failures = 0;
  logic [8:0] att[$];
  logic       nxt_we;
  logic [15:0] nxt_addr;
  logic [7:0]  nxt_wd;

  mem_access_master #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(RD_LAT), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_perr(rsp_perr), .rsp_retries(rsp_retries),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pad the per-attempt readback list with random words so every attempt has one.
  task automatic fill_att();
    while (att.size() < MAXR + 1) att.push_back(9'($urandom));
  endtask

  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input int stall, input bit hold_next);
    int nrd = 0, nwr = 0, vcyc = -1, stalled = 0, exp_ret, exp_lat;
    bit ok = 0, done = 0, found = 0;
    logic [7:0] exp_d;
    logic exp_perr;
    // Model: first good attempt within the retry budget wins; otherwise the last one.
    exp_ret = 0; exp_perr = 1'b0; exp_d = 8'h00;
    if (!we) begin
      fill_att();
      for (int k = 0; k <= MAXR; k++)
        if (!found && (^att[k]) == 1'b0) begin
          found = 1; exp_ret = k; exp_d = att[k][7:0];
        end
      if (!found) begin
        exp_ret = MAXR; exp_perr = 1'b1; exp_d = att[MAXR][7:0];
      end
    end
    exp_lat = we ? 2 : (exp_ret + 1) * (1 + RD_LAT) + 1;

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) ok = 1;
      else @(negedge clk);
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      if (mem_write && mem_read) chk("strobe_overlap", 32'd1, 32'd0);
      if (mem_write) begin
        nwr++;
        chk("wr_addr", 32'(mem_address), 32'(addr));
        chk("wr_data", 32'(mem_data_in), 32'(wd));
      end
      if (mem_read) begin
        chk("rd_addr", 32'(mem_address), 32'(addr));
        mem_data_out = (nrd < att.size()) ? att[nrd] : 9'h000;
        nrd++;
      end
      if (rsp_valid) begin
        chk("rsp_fields", {rsp_rdata, 7'd0, rsp_perr, 5'd0, rsp_retries},
            {exp_d, 7'd0, exp_perr, 5'd0, 3'(exp_ret)});
        chk("rsp_req_ready_low", 32'(req_ready), 32'd0);
        if (vcyc < 0) begin
          vcyc = cyc;
          chk("rsp_latency", 32'(vcyc), 32'(exp_lat));
          if (hold_next) begin
            req_valid = 1'b1; req_we = nxt_we; req_addr = nxt_addr; req_wdata = nxt_wd;
          end
        end
        if (stalled >= stall) begin
          rsp_ready = 1'b1;
          @(posedge clk);
          #1 rsp_ready = 1'b0;
          done = 1;
        end else stalled++;
      end
    end
    chk("rsp_timeout", 32'(done), 32'd1);
    chk("wr_pulses", 32'(nwr), we ? 32'd1 : 32'd0);
    chk("rd_pulses", 32'(nrd), we ? 32'd0 : 32'(exp_ret + 1));
    att = {};
  endtask

  initial begin
    bit we;
    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", {rsp_valid, mem_write, mem_read, busy, rsp_perr}, 5'd0);
    chk("rst_rsp", {rsp_rdata, rsp_retries}, 11'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("busy_after_rst", 32'(busy), 32'd0);

    run_txn(1'b1, 16'h1234, 8'hA5, 0, 0);
    att.push_back(9'h101);
    run_txn(1'b0, 16'h00FF, 8'h00, 1, 0);
    att.push_back(9'h001); att.push_back(9'h101);
    run_txn(1'b0, 16'h0F0F, 8'h00, 0, 0);
    att.push_back(9'h007); att.push_back(9'h007); att.push_back(9'h007);
    run_txn(1'b0, 16'hABCD, 8'h00, 0, 0);

    // Stall response 5 cycles while the next request waits on the bus.
    nxt_we = 1'b0; nxt_addr = 16'h4321; nxt_wd = 8'h00;
    run_txn(1'b1, 16'hBEEF, 8'h3C, 5, 1);
    att.push_back(9'h155);
    run_txn(1'b0, 16'h4321, 8'h00, 0, 0);

    // Reset asserted in WAIT drops the transaction with no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h5555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_read", 32'(mem_read), 32'd1);
    mem_data_out = 9'h101;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {rsp_valid, mem_write, mem_read, busy, req_ready}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, mem_read, mem_write}, 3'd0);
    end
    att.push_back(9'h0FF);
    run_txn(1'b0, 16'h6666, 8'h00, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom);
      fill_att();
      run_txn(we, 16'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator-side controller for the 8-bit-data / 16-bit-address / 9-bit-parity-readback memory interface.
- Accepts single read or write requests over a valid/ready request channel.
- Drives write/read/address/data_in to the memory responder, then captures the 9-bit data_out and checks even parity (bit 8 = XOR of bits 7:0).
- Returns one response per request, retrying reads that fail parity; sits between a test sequencer or CPU-side agent and the memory.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width; readback is DATA_W+1.
- RD_LATENCY, 1, cycles from the mem_read-high cycle to the edge that samples mem_data_out (1..7).
- MAX_RETRY, 2, read reissues allowed after a parity error (0..7).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_perr  out  1  final read attempt failed parity
- rsp_retries  out  3  reissues performed
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W+1  memory readback, parity in MSB
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: async on rst_n low. All outputs 0, except req_ready = 1 after reset release. FSM goes to IDLE, retry count clears, and any in-flight transaction is dropped with no response.
- All outputs are registered. mem_write and mem_read are never high together.
- States:
  - IDLE: req_ready = 1. On req_valid, capture we/addr/wdata, clear retries; go to WR if we = 1, else RD.
  - WR: mem_write = 1, address and data_in driven, for exactly one cycle; then go to RESP.
  - RD: mem_read = 1 and address driven for exactly one cycle; load wait counter with RD_LATENCY-1; go to WAIT.
  - WAIT: counter decrements each cycle. At the edge where it reaches 0, sample mem_data_out.
    - Parity good (XOR of all 9 bits = 0): go to RESP with perr = 0.
    - Parity bad and retries < MAX_RETRY: retries++, go back to RD.
    - Parity bad and retries = MAX_RETRY: go to RESP with perr = 1.
  - RESP: rsp_valid = 1 with rsp_rdata/rsp_perr/rsp_retries held stable until rsp_ready. The handshake edge returns to IDLE. rsp_ready low stalls indefinitely; req_ready stays 0.
- Latency (rsp_ready tied high, request accepted at edge E0):
  - Write: mem_write high in cycle 1; rsp_valid high in cycle 2.
  - Read, RD_LATENCY = 1, no error: mem_read high in cycle 1; data sampled at end of cycle 2; rsp_valid high in cycle 3.
  - Each retry adds 1 + RD_LATENCY cycles.
- mem_address and mem_data_in hold their last driven value outside strobes; only strobe-cycle values are meaningful.
- rsp_rdata returns the data bits of the final attempt, even when perr = 1.
- Requests presented while req_ready = 0 are ignored (not captured); the source must hold them.
- After a write, rsp_perr = 0 and rsp_retries = 0.

Decomposition:
- Package mem_access_pkg holds:
  - state enum {IDLE, WR, RD, WAIT, RESP};
  - ADDR_W/DATA_W defaults;
  - function even_parity_ok(logic [8:0]) returning ~^ of all bits.
- No sub-module required; the FSM, wait counter and retry counter live in one module.

Test Plan:
- Write addr 16'h1234, data 8'hA5 -> mem_write high exactly one cycle with mem_address = 16'h1234 and mem_data_in = 8'hA5; rsp_valid on the 2nd cycle after acceptance with perr = 0 and retries = 0.
- Read addr 16'h00FF; responder returns 9'h1_01 (data 01, parity 1) -> single mem_read; rsp_rdata = 8'h01, perr = 0, retries = 0, rsp_valid 3 cycles after acceptance.
- Read with responder returning bad parity 9'h0_01 then good 9'h1_01 -> exactly two mem_read pulses; rsp_rdata = 8'h01, perr = 0, retries = 1.
- Read with persistent bad parity 9'h0_07, MAX_RETRY = 2 -> exactly three mem_read pulses; perr = 1, retries = 2, rdata = 8'h07.
- Hold rsp_ready low 5 cycles with a second req_valid asserted -> rsp fields stable, req_ready = 0, no new mem strobe; second request accepted only after the handshake edge.
- Assert rst_n low during WAIT -> all mem strobes and rsp_valid drop immediately, busy = 0, no response emitted; a new read after release completes normally.
